// File: rtl/motion_frame_ctrl.sv
// Frame sequencer for the downsampled motion-difference path: gates pixels, runs warmup,
// counts motion hits per RUN frame, publishes the count and drives a held-off alarm.
module motion_frame_ctrl #(
  parameter int unsigned DS_W          = 320,
  parameter int unsigned DS_H          = 180,
  parameter int unsigned CNT_W         = 17,
  parameter int unsigned WARMUP_FRAMES = 2,
  parameter int unsigned HOLD_FRAMES   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enable,
  input  logic             i_sof,
  input  logic             i_vld,
  input  logic [11:0]      i_x,
  input  logic [10:0]      i_y,
  input  logic             i_motion,
  input  logic [CNT_W-1:0] i_thresh,
  output logic             o_diff_vld,
  output logic             o_frame_done,
  output logic [CNT_W-1:0] o_motion_cnt,
  output logic             o_alarm,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWarmup = 2'd1,
    StRun    = 2'd2
  } state_e;

  localparam logic [9:0]       DsW      = 10'(DS_W);
  localparam logic [8:0]       DsH      = 9'(DS_H);
  localparam logic [3:0]       WarmLast = 4'(WARMUP_FRAMES - 1);
  localparam logic [7:0]       HoldInit = 8'(HOLD_FRAMES);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  state_e           state_q;
  logic [3:0]       warm_q;
  logic [7:0]       hold_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] motion_cnt_q;
  logic             hit_q;
  logic             frame_done_q;
  logic             alarm_q;

  logic             ds_hit;
  logic             diff_vld;
  logic             inc;
  logic [CNT_W-1:0] cnt_inc;

  assign ds_hit = i_vld && (i_x[1:0] == 2'b00) && (i_y[1:0] == 2'b00) &&
                  (i_x[11:2] < DsW) && (i_y[10:2] < DsH);

  // The SOF pixel that opens warmup must reach the difference block to seed its map.
  assign diff_vld = i_vld && ((state_q != StIdle) || (i_enable && i_sof));

  // A hit_q seen in the SOF cycle still belongs to the frame being closed.
  assign inc     = hit_q && i_motion && (state_q == StRun);
  assign cnt_inc = (inc && (cnt_q != '1)) ? cnt_q + CntOne : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      warm_q       <= '0;
      hold_q       <= '0;
      cnt_q        <= '0;
      motion_cnt_q <= '0;
      hit_q        <= 1'b0;
      frame_done_q <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      hit_q        <= ds_hit && diff_vld;
      frame_done_q <= 1'b0;
      if (!i_enable) begin
        state_q <= StIdle;
        warm_q  <= '0;
        hold_q  <= '0;
        cnt_q   <= '0;
        alarm_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (i_sof) begin
              state_q <= StWarmup;
              warm_q  <= '0;
            end
          end
          StWarmup: begin
            if (i_sof) begin
              if (warm_q == WarmLast) begin
                state_q <= StRun;
                cnt_q   <= '0;
              end else begin
                warm_q <= warm_q + 4'd1;
              end
            end
          end
          StRun: begin
            if (i_sof) begin
              motion_cnt_q <= cnt_inc;
              frame_done_q <= 1'b1;
              cnt_q        <= '0;
              if (cnt_inc >= i_thresh) begin
                alarm_q <= 1'b1;
                hold_q  <= HoldInit;
              end else if (hold_q != 8'd0) begin
                alarm_q <= 1'b1;
                hold_q  <= hold_q - 8'd1;
              end else begin
                alarm_q <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign o_diff_vld   = diff_vld;
  assign o_frame_done = frame_done_q;
  assign o_motion_cnt = motion_cnt_q;
  assign o_alarm      = alarm_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_motion_frame_ctrl.sv
// Bench for motion_frame_ctrl: directed and randomized frames checked every cycle against a
// frame-level model (frames since enable, hits per frame, alarm hold-off).
module tb_motion_frame_ctrl;

  localparam int DS_W  = 320;
  localparam int DS_H  = 180;
  localparam int CNT_W = 17;
  localparam int WARM  = 2;
  localparam int HOLD  = 1;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_enable;
  logic             i_sof;
  logic             i_vld;
  logic [11:0]      i_x;
  logic [10:0]      i_y;
  logic             i_motion;
  logic [CNT_W-1:0] i_thresh;
  logic             o_diff_vld;
  logic             o_frame_done;
  logic [CNT_W-1:0] o_motion_cnt;
  logic             o_alarm;
  logic [1:0]       o_state;

  motion_frame_ctrl #(
    .DS_W(DS_W), .DS_H(DS_H), .CNT_W(CNT_W), .WARMUP_FRAMES(WARM), .HOLD_FRAMES(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_sof(i_sof), .i_vld(i_vld),
    .i_x(i_x), .i_y(i_y), .i_motion(i_motion), .i_thresh(i_thresh),
    .o_diff_vld(o_diff_vld), .o_frame_done(o_frame_done), .o_motion_cnt(o_motion_cnt),
    .o_alarm(o_alarm), .o_state(o_state)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int npass = 0;

  // Model: m_sof = SOFs seen since enable; frames after the first WARM are RUN frames.
  bit en;
  int thr;
  int m_sof, m_cur, m_hold;
  int exp_cnt;
  bit exp_alarm, exp_done;
  bit mot_pipe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int exp_state();
    if (m_sof == 0) return 0;
    if (m_sof <= WARM) return 1;
    return 2;
  endfunction

  function automatic bit on_grid(input logic [11:0] x, input logic [10:0] y);
    int xi, yi;
    xi = int'(x);
    yi = int'(y);
    return (xi % 4 == 0) && (xi / 4 < DS_W) && (yi % 4 == 0) && (yi / 4 < DS_H);
  endfunction

  task automatic check_outs();
    chk("state", 32'(o_state), 32'(exp_state()));
    chk("frame_done", 32'(o_frame_done), 32'(exp_done));
    chk("motion_cnt", 32'(o_motion_cnt), 32'(exp_cnt));
    chk("alarm", 32'(o_alarm), 32'(exp_alarm));
  endtask

  // kind: 0 on-grid in range, 1 off-grid, 2 out of range, 3 any of those
  task automatic rand_pix(input int kind, output logic [11:0] x, output logic [10:0] y);
    int k;
    k = (kind == 3) ? int'($urandom_range(0, 2)) : kind;
    x = 12'($urandom_range(0, DS_W - 1) * 4);
    y = 11'($urandom_range(0, DS_H - 1) * 4);
    if (k == 1) begin
      if ($urandom_range(0, 1) == 1) x = x + 12'($urandom_range(1, 3));
      else y = y + 11'($urandom_range(1, 3));
    end else if (k == 2) begin
      if ($urandom_range(0, 1) == 1) x = 12'($urandom_range(DS_W, 1023) * 4);
      else y = 11'($urandom_range(DS_H, 511) * 4);
    end
  endtask

  task automatic step(input bit sof, input bit vld, input logic [11:0] x, input logic [10:0] y,
                      input bit mot);
    bit e_dv;
    int c;
    @(negedge clk);
    i_enable = en;
    i_sof    = sof;
    i_vld    = vld;
    i_x      = x;
    i_y      = y;
    i_motion = mot_pipe;
    i_thresh = CNT_W'(thr);
    #1;
    e_dv = vld && ((m_sof > 0) || (en && sof));
    chk("diff_vld", 32'(o_diff_vld), 32'(e_dv));
    exp_done = 1'b0;
    if (!en) begin
      m_sof = 0; m_cur = 0; m_hold = 0; exp_alarm = 1'b0;
    end else begin
      if (sof) begin
        if (m_sof > WARM) begin
          c = (m_cur > MAXC) ? MAXC : m_cur;
          exp_cnt  = c;
          exp_done = 1'b1;
          if (c >= thr) begin
            exp_alarm = 1'b1; m_hold = HOLD;
          end else if (m_hold > 0) begin
            exp_alarm = 1'b1; m_hold = m_hold - 1;
          end else begin
            exp_alarm = 1'b0;
          end
        end
        if (m_sof <= WARM) m_sof = m_sof + 1;
        m_cur = 0;
      end
      if (m_sof > WARM && vld && on_grid(x, y) && mot) m_cur = m_cur + 1;
    end
    mot_pipe = mot;
    @(posedge clk);
    #1;
    check_outs();
  endtask

  // mode: 0 idle filler, 1 random pixels, 2 off-grid/out-of-range pixels with motion=1
  task automatic frame(input int len, input int hits, input int mode, input bit last_hit);
    logic [11:0] x;
    logic [10:0] y;
    bit v, m;
    for (int i = 0; i < len; i++) begin
      if ((last_hit && i == len - 1) || i < hits) begin
        rand_pix(0, x, y); v = 1'b1; m = 1'b1;
      end else if (mode == 1) begin
        rand_pix(3, x, y); v = bit'($urandom_range(0, 1)); m = bit'($urandom_range(0, 1));
      end else if (mode == 2) begin
        rand_pix(int'($urandom_range(1, 2)), x, y); v = 1'b1; m = 1'b1;
      end else begin
        x = '0; y = '0; v = 1'b0; m = bit'($urandom_range(0, 1));
      end
      step(i == 0, v, x, y, m);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; i_sof = 1'b0; i_vld = 1'b0; i_motion = 1'b0;
    #1;
    m_sof = 0; m_cur = 0; m_hold = 0; exp_cnt = 0; exp_alarm = 1'b0; exp_done = 1'b0;
    mot_pipe = 1'b0;
    check_outs();
    @(posedge clk);
    #1;
    check_outs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [11:0] x;
    logic [10:0] y;
    en = 1'b0; thr = 100;
    m_sof = 0; m_cur = 0; m_hold = 0; exp_cnt = 0; exp_alarm = 1'b0; exp_done = 1'b0;
    mot_pipe = 1'b0;
    rst_n = 1'b0; i_enable = 1'b0; i_sof = 1'b0; i_vld = 1'b0; i_x = '0; i_y = '0;
    i_motion = 1'b0; i_thresh = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outs();
    @(negedge clk);
    rst_n = 1'b1;

    // Disabled: SOFs are ignored and nothing is passed through
    frame(3, 2, 0, 1'b0);
    // Enabled without SOF: IDLE is held
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_pix(0, x, y);
      step(1'b0, 1'b1, x, y, 1'b1);
    end

    // Warmup then first published count of 5
    for (int f = 0; f < 4; f++) frame(8, 5, 0, 1'b0);
    // Alarm with hold-off: counts 12, 3, 3 against threshold 10
    thr = 10;
    frame(14, 12, 0, 1'b0);
    frame(6, 3, 0, 1'b0);
    frame(6, 3, 0, 1'b0);
    frame(6, 3, 0, 1'b0);
    // Hit on last pixel, its motion arriving in the next SOF cycle
    frame(6, 0, 0, 1'b1);
    frame(6, 0, 0, 1'b0);
    // Off-grid and out-of-range pixels with motion forced high
    frame(10, 0, 2, 1'b0);
    frame(4, 0, 0, 1'b0);
    // Drop enable mid-frame
    thr = 0;
    frame(20, 12, 0, 1'b0);
    frame(5, 3, 0, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_pix(0, x, y);
      step(1'b0, 1'b1, x, y, 1'b1);
    end
    // Reset mid-warmup, then warmup restarts only on a SOF
    en = 1'b1;
    frame(4, 2, 0, 1'b0);
    frame(3, 1, 1, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rand_pix(0, x, y);
      step(1'b0, 1'b1, x, y, 1'b1);
    end
    for (int f = 0; f < 4; f++) frame(6, 2, 1, 1'b0);

    // Randomized frames with occasional disable bursts
    for (int f = 0; f < 40; f++) begin
      thr = int'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) begin
        en = 1'b0;
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
          rand_pix(3, x, y);
          step(bit'($urandom_range(0, 1)), 1'b1, x, y, bit'($urandom_range(0, 1)));
        end
        en = 1'b1;
      end
      frame(int'($urandom_range(4, 20)), int'($urandom_range(0, 3)), 1,
            bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
